// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory access stage.
//   state_t        - access FSM state encoding
//   *_DEF          - parameter defaults for mem_access_unit and mem_wb_reg
package mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int WORD_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 4;
    localparam int ADDR_W_DEF     = 16;
    localparam int BASE_ADDR_DEF  = 1024;
    localparam int TIMEOUT_DEF    = 255;

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with bubble insertion.
//   clk, rst      - clock, synchronous active-low reset (clears every field)
//   bubble        - load a bubble: wb_en_out and wb_mem_read cleared, other fields held
//   load_data     - when not a bubble, also capture mem_data into wb_mem_data
//   dst, alu_res, mem_data, mem_read, wb_en - next-stage field values
//   wb_dst, wb_alu_res, wb_mem_data, wb_mem_read, wb_en_out - registered fields
module mem_wb_reg
    import mem_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bubble,
    input  logic                  load_data,
    input  logic [REG_ADDR_W-1:0] dst,
    input  logic [WORD_W-1:0]     alu_res,
    input  logic [WORD_W-1:0]     mem_data,
    input  logic                  mem_read,
    input  logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic [WORD_W-1:0]     wb_alu_res,
    output logic [WORD_W-1:0]     wb_mem_data,
    output logic                  wb_mem_read,
    output logic                  wb_en_out
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_dst      <= '0;
            wb_alu_res  <= '0;
            wb_mem_data <= '0;
            wb_mem_read <= 1'b0;
            wb_en_out   <= 1'b0;
        end else if (bubble) begin
            wb_mem_read <= 1'b0;
            wb_en_out   <= 1'b0;
        end else begin
            wb_dst      <= dst;
            wb_alu_res  <= alu_res;
            wb_mem_read <= mem_read;
            wb_en_out   <= wb_en;
            // stores and ALU ops leave the last load data in place
            if (load_data)
                wb_mem_data <= mem_data;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: pipeline memory stage. ALU results pass straight to the
// WB register; loads/stores stall upstream while a single-outstanding
// request is held on the memory port until mem_ready.
//   clk, rst          - clock, synchronous active-low reset
//   dst, alu_res, val_rm, mem_read, mem_write, wb_en - from EXE/MEM
//   mem_req, mem_we, mem_addr, mem_wdata, mem_ready, mem_rdata - memory port
//   stall             - freeze upstream pipeline registers
//   wb_*              - registered fields to write-back
//   mem_err           - sticky access timeout error
// Build option: define MEM_TIMEOUT_EN to enable the ACCESS wait timeout;
// otherwise ACCESS waits indefinitely and mem_err is constant 0.
//
// state  | meaning
// IDLE   | pass ALU ops through; accept a load/store and latch it
// ACCESS | request held on the memory port until mem_ready (or timeout)
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BASE_ADDR  = BASE_ADDR_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] dst,
    input  logic [WORD_W-1:0]     alu_res,
    input  logic [WORD_W-1:0]     val_rm,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  wb_en,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic [WORD_W-1:0]     mem_rdata,
    output logic                  stall,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic [WORD_W-1:0]     wb_alu_res,
    output logic [WORD_W-1:0]     wb_mem_data,
    output logic                  wb_mem_read,
    output logic                  wb_en_out,
    output logic                  mem_err
);

    state_t                  state;
    logic [REG_ADDR_W-1:0]   lat_dst;
    logic [WORD_W-1:0]       lat_alu;
    logic                    lat_wb_en;
    logic                    lat_rd;

    logic                    wb_bubble;
    logic                    wb_load;
    logic [REG_ADDR_W-1:0]   wb_dst_in;
    logic [WORD_W-1:0]       wb_alu_in;
    logic                    wb_rd_in;
    logic                    wb_en_in;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // down-counter: abort on the edge ending the TIMEOUT-th wait cycle
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_dst   <= '0;
            lat_alu   <= '0;
            lat_wb_en <= 1'b0;
            lat_rd    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        state     <= ACCESS;
                        mem_req   <= 1'b1;
                        mem_we    <= mem_write;
                        mem_addr  <= ADDR_W'((alu_res - WORD_W'(BASE_ADDR)) >> 2);
                        mem_wdata <= val_rm;
                        lat_dst   <= dst;
                        lat_alu   <= alu_res;
                        lat_wb_en <= wb_en;
                        // simultaneous read+write is treated as a pure store
                        lat_rd    <= mem_read & ~mem_write;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt  <= CNT_W'(TIMEOUT - 1);
`endif
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == '0) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MEM_TIMEOUT_EN
    // TIMEOUT only sizes the wait counter, which is absent in this build
    assign mem_err = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

    assign stall = rst && ((state == IDLE) ? (mem_read || mem_write) : !mem_ready);

    always_comb begin
        wb_bubble = mem_read || mem_write;
        wb_load   = 1'b0;
        wb_dst_in = dst;
        wb_alu_in = alu_res;
        wb_rd_in  = 1'b0;
        wb_en_in  = wb_en;
        if (state == ACCESS) begin
            wb_bubble = !mem_ready;
            wb_load   = lat_rd;
            wb_dst_in = lat_dst;
            wb_alu_in = lat_alu;
            wb_rd_in  = lat_rd;
            wb_en_in  = lat_wb_en;
        end
    end

    mem_wb_reg #(
        .WORD_W     (WORD_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_wb_reg (
        .clk         (clk),
        .rst         (rst),
        .bubble      (wb_bubble),
        .load_data   (wb_load),
        .dst         (wb_dst_in),
        .alu_res     (wb_alu_in),
        .mem_data    (mem_rdata),
        .mem_read    (wb_rd_in),
        .wb_en       (wb_en_in),
        .wb_dst      (wb_dst),
        .wb_alu_res  (wb_alu_res),
        .wb_mem_data (wb_mem_data),
        .wb_mem_read (wb_mem_read),
        .wb_en_out   (wb_en_out)
    );

endmodule
